tt_mux_sel_seq: RTL

Sequencer that drives the shared TinyTapeout mux control lines (select-reset, select-increment, enable) to activate one user project by address. It accepts a target address from the autosel front end, deselects the current project, clears the mux address counter, and emits exactly N increment pulses. It then waits for the mux to settle and asserts enable. It is the single owner of the mux control pins inside `tt_um_autosel`.

---
 rtl/tt_mux_sel_seq.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/tt_mux_sel_seq.sv
// Drives the TinyTapeout mux control lines to select one user project by address.
// Optional abort input enabled by defining TT_MUX_SEL_ABORT_EN.
module tt_mux_sel_seq #(
  parameter int unsigned ADDR_W        = 10,
  parameter int unsigned PULSE_CYCLES  = 2,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
`ifdef TT_MUX_SEL_ABORT_EN
  input  logic              abort,
`endif
  output logic              ctrl_sel_rst_n,
  output logic              ctrl_sel_inc,
  output logic              ctrl_ena,
  output logic              busy,
  output logic              done
);

  localparam int unsigned MaxCycles =
      (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CntW = $clog2(MaxCycles) + 1;
  localparam logic [CntW-1:0] PulseLd  = CntW'(PULSE_CYCLES - 1);
  localparam logic [CntW-1:0] SettleLd = CntW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle, StDesel, StRstLo, StRstHi, StIncHi, StIncLo, StSettle, StEna
  } state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [ADDR_W-1:0] remaining_q;
  logic              abort_req;

`ifdef TT_MUX_SEL_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Outputs are set alongside the state they belong to, so they are all registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      remaining_q    <= '0;
      ctrl_sel_rst_n <= 1'b1;
      ctrl_sel_inc   <= 1'b0;
      ctrl_ena       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort_req && (state_q != StIdle)) begin
        state_q        <= StIdle;
        cnt_q          <= '0;
        ctrl_sel_rst_n <= 1'b1;
        ctrl_sel_inc   <= 1'b0;
        ctrl_ena       <= 1'b0;
        busy           <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start && !abort_req) begin
              state_q     <= StDesel;
              remaining_q <= addr;
              cnt_q       <= SettleLd;
              busy        <= 1'b1;
              ctrl_ena    <= 1'b0;
            end
          end
          StDesel: begin
            if (cnt_q == '0) begin
              state_q        <= StRstLo;
              cnt_q          <= PulseLd;
              ctrl_sel_rst_n <= 1'b0;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          StRstLo: begin
            if (cnt_q == '0) begin
              state_q        <= StRstHi;
              cnt_q          <= PulseLd;
              ctrl_sel_rst_n <= 1'b1;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          StRstHi: begin
            if (cnt_q == '0) begin
              if (remaining_q == '0) begin
                state_q <= StSettle;
                cnt_q   <= SettleLd;
              end else begin
                state_q      <= StIncHi;
                cnt_q        <= PulseLd;
                ctrl_sel_inc <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          StIncHi: begin
            if (cnt_q == '0) begin
              state_q      <= StIncLo;
              cnt_q        <= PulseLd;
              ctrl_sel_inc <= 1'b0;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          StIncLo: begin
            if (cnt_q == '0) begin
              remaining_q <= remaining_q - 1'b1;
              // Compare the pre-decrement value so the last pulse exits to settle.
              if (remaining_q == ADDR_W'(1)) begin
                state_q <= StSettle;
                cnt_q   <= SettleLd;
              end else begin
                state_q      <= StIncHi;
                cnt_q        <= PulseLd;
                ctrl_sel_inc <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          StSettle: begin
            if (cnt_q == '0) begin
              state_q  <= StEna;
              ctrl_ena <= 1'b1;
              done     <= 1'b1;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          StEna: begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule
